// File: rtl/param_load_shifter_if.sv
// param_load_shifter_if
//   Groups the load/step controls and the register outputs of param_load_shifter.
//   master: the block driving Load/Din/mode/en/ser_in and observing the results.
//   slave : the shifter itself.
// Signals
//   Load     parallel-load strobe
//   Din      parallel load data (WIDTH)
//   mode     00 hold, 01 shift left, 10 shift right, 11 rotate left
//   en       step enable while busy
//   ser_in   serial fill bit for the shift modes
//   Dout     register contents (WIDTH)
//   ser_out  serial output bit
//   bit_cnt  steps taken since the last Load (CNT_W)
//   busy     word in progress
//   done     one-cycle completion pulse
interface param_load_shifter_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
);
    logic             Load;
    logic [WIDTH-1:0] Din;
    logic [1:0]       mode;
    logic             en;
    logic             ser_in;
    logic [WIDTH-1:0] Dout;
    logic             ser_out;
    logic [CNT_W-1:0] bit_cnt;
    logic             busy;
    logic             done;

    modport master (
        output Load, Din, mode, en, ser_in,
        input  Dout, ser_out, bit_cnt, busy, done
    );

    modport slave (
        input  Load, Din, mode, en, ser_in,
        output Dout, ser_out, bit_cnt, busy, done
    );
endinterface

// File: rtl/param_load_shifter.sv
// param_load_shifter
//   Loadable shift/rotate register with a step counter and a three-state control FSM.
//   A Load pulse captures Din; the word then takes exactly WIDTH enabled steps,
//   after which done pulses for one cycle and the block returns to idle.
// Ports
//   clk    rising-edge clock
//   rst_n  synchronous reset, active low
//   bus    param_load_shifter_if.slave (Load, Din, mode, en, ser_in in;
//          Dout, ser_out, bit_cnt, busy, done out)
module param_load_shifter #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic                 clk,
    input logic                 rst_n,
    param_load_shifter_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    localparam logic [1:0] ModeHold  = 2'b00;
    localparam logic [1:0] ModeLeft  = 2'b01;
    localparam logic [1:0] ModeRight = 2'b10;
    localparam logic [1:0] ModeRotL  = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        cnt_d   = cnt_q;

        // Load wins over any step in progress, in every state.
        if (bus.Load) begin
            dout_d  = bus.Din;
            cnt_d   = '0;
            state_d = StShift;
        end else begin
            case (state_q)
                StShift: begin
                    if (bus.en && (bus.mode != ModeHold)) begin
                        case (bus.mode)
                            ModeLeft:  dout_d = {dout_q[WIDTH-2:0], bus.ser_in};
                            ModeRight: dout_d = {bus.ser_in, dout_q[WIDTH-1:1]};
                            ModeRotL:  dout_d = {dout_q[WIDTH-2:0], dout_q[WIDTH-1]};
                            default:   dout_d = dout_q;
                        endcase
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            state_d = StDone;
                        end
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            dout_q  <= RESET_VAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.Dout    = dout_q;
    assign bus.bit_cnt = cnt_q;
    assign bus.busy    = (state_q == StShift);
    assign bus.done    = (state_q == StDone);
    // Left-moving modes emit the MSB; right shift and hold emit the LSB.
    assign bus.ser_out = (bus.mode == ModeLeft || bus.mode == ModeRotL) ?
                         dout_q[WIDTH-1] : dout_q[0];
endmodule
